// File: rtl/uart_receiver.sv
// UART receive path: 4x-oversampled start/data/parity/stop recovery with valid/ready output.
// Defining UART_RX_BREAK_DETECT_EN adds a one-clk break_det pulse on all-zero framing-error words.
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sample_tick,
    input  logic [1:0] PARITY_MODE,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       break_det
);

    // state      | meaning
    // S_IDLE     | line idle, waiting for rx_s low
    // S_START    | qualifying start bit at its midpoint
    // S_DATA     | sampling data (and parity) bits
    // S_STOP     | sampling the first stop bit, completing the word
    // S_WAIT_IDLE| framing error seen, waiting for line to return high
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state;
    logic [2:0]             tick_cnt;
    logic [3:0]             bit_cnt;
    logic [8:0]             shift_q;
    logic [1:0]             mode_q;

    logic       par_en;
    logic [3:0] last_bit;
    logic [7:0] data_w;
    logic       par_bit;
    logic       exp_par;
    logic       complete;

    // Preset to 1 so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    assign par_en   = (mode_q == 2'd1) || (mode_q == 2'd2);
    assign last_bit = par_en ? 4'd8 : 4'd7;
    // Bits enter at the top and shift right, so 8-bit frames sit one position higher.
    assign data_w   = par_en ? shift_q[7:0] : shift_q[8:1];
    assign par_bit  = shift_q[8];
    assign exp_par  = (mode_q == 2'd1) ? ~^data_w : ^data_w;
    assign complete = (state == S_STOP) && sample_tick && (tick_cnt == 3'd3);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            tick_cnt <= 3'd0;
            bit_cnt  <= 4'd0;
            shift_q  <= 9'd0;
            mode_q   <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        tick_cnt <= 3'd0;
                        mode_q   <= PARITY_MODE;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        if (tick_cnt == 3'd1) begin
                            if (rx_s) begin
                                state <= S_IDLE;
                            end else begin
                                state    <= S_DATA;
                                tick_cnt <= 3'd0;
                                bit_cnt  <= 4'd0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 3'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        if (tick_cnt == 3'd3) begin
                            shift_q  <= {rx_s, shift_q[8:1]};
                            tick_cnt <= 3'd0;
                            if (bit_cnt == last_bit)
                                state <= S_STOP;
                            else
                                bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        if (tick_cnt == 3'd3) begin
                            state    <= rx_s ? S_IDLE : S_WAIT_IDLE;
                            tick_cnt <= 3'd0;
                        end else begin
                            tick_cnt <= tick_cnt + 3'd1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Error flags travel with the word and are only replaced on the next completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            rx_data    <= data_w;
            parity_err <= par_en && (par_bit != exp_par);
            frame_err  <= ~rx_s;
            overrun    <= rx_valid & ~rx_ready;
            rx_valid   <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            break_det <= 1'b0;
        else
            break_det <= complete && !rx_s && (data_w == 8'd0) && (!par_en || !par_bit);
    end
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a tick-arithmetic frame/handshake model checked every cycle,
// plus literal expectations after each scenario.
module tb_uart_receiver;

`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       sample_tick;
    logic [1:0] PARITY_MODE;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       break_det;

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sample_tick (sample_tick),
        .PARITY_MODE (PARITY_MODE),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .break_det   (break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         perr;
        bit         ferr;
        bit         brk;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ready_pulse_at = -1;
    int         brk_count = 0;

    bit         m_valid = 0;
    logic [7:0] m_data = 8'd0;
    bit         m_perr = 0;
    bit         m_ferr = 0;
    bit         m_ovr = 0;
    bit         m_brk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // One clk cycle: advance tick generator and model, then drive rx_ready.
    task automatic step();
        bit   prev_ready;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        sample_tick = (cyc % 8 == 0);
        prev_ready  = rx_ready;
        if (!resetn) begin
            m_valid = 0; m_data = 8'd0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_brk = 0;
            exp_q.delete();
        end else begin
            m_brk = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
                e       = exp_q.pop_front();
                m_ovr   = m_valid && !prev_ready;
                m_valid = 1;
                m_data  = e.data;
                m_perr  = e.perr;
                m_ferr  = e.ferr;
                m_brk   = e.brk;
            end else if (m_valid && prev_ready) begin
                m_valid = 0;
            end
        end
        rx_ready = (cyc == ready_pulse_at);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_valid", rx_valid, 0);
            chk("rst_data", rx_data, 0);
            chk("rst_flags", {parity_err, frame_err, overrun, break_det}, 0);
        end else begin
            chk("rx_valid", rx_valid, m_valid);
            if (m_valid) begin
                chk("rx_data", rx_data, m_data);
                chk("parity_err", parity_err, m_perr);
                chk("frame_err", frame_err, m_ferr);
                chk("overrun", overrun, m_ovr);
            end
            chk("break_det", break_det, m_brk);
        end
        if (break_det) brk_count++;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) step();
    endtask

    task automatic accept();
        ready_pulse_at = cyc + 1;
        step();
        step();
        chk("accept_clears_valid", rx_valid, 0);
    endtask

    // Drives one frame at 32 clk per bit; predicts completion from tick arithmetic:
    // rx_s falls 2 clk after rx, the 2nd tick after that checks the start bit,
    // then each of the N data bits and the stop bit take 4 ticks.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] mode, input bit par,
                              input bit stop, input int extra_low, input int accept_after);
        int   e, d, t2, n, c;
        bit   pen;
        exp_t x;
        pen = (mode == 2'd1) || (mode == 2'd2);
        n   = pen ? 9 : 8;
        e   = cyc;
        d   = e + 2;
        t2  = (d / 8 + 1) * 8 + 8;
        c   = t2 + 32 * (n + 1);
        x.cyc  = c;
        x.data = data;
        x.perr = pen && (par != ((mode == 2'd1) ? ~^data : ^data));
        x.ferr = !stop;
        x.brk  = BRK_EN && !stop && (data == 8'd0) && (!pen || !par);
        exp_q.push_back(x);
        if (accept_after >= 0) ready_pulse_at = c + accept_after;
        PARITY_MODE = mode;
        rx = 1'b0;
        repeat (32) step();
        PARITY_MODE = ~mode;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (32) step();
        end
        if (pen) begin
            rx = par;
            repeat (32) step();
        end
        rx = stop;
        repeat (32) step();
        if (extra_low > 0) begin
            rx = 1'b0;
            repeat (32 * extra_low) step();
        end
        rx = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; rx = 1'b1; rx_ready = 1'b0; PARITY_MODE = 2'd0; sample_tick = 1'b0;
        repeat (4) step();
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 8'h00);
        resetn = 1'b1;
        idle(20);

        // No parity, 0xA5
        send_frame(8'hA5, 2'd0, 1'b0, 1'b1, 0, -1);
        idle(10);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_flags", {parity_err, frame_err, overrun}, 3'b000);
        accept();

        // Odd parity 0x3C: correct parity bit 1, then wrong bit 0
        send_frame(8'h3C, 2'd1, 1'b1, 1'b1, 0, -1);
        idle(10);
        chk("odd_ok_data", rx_data, 8'h3C);
        chk("odd_ok_perr", parity_err, 0);
        accept();
        send_frame(8'h3C, 2'd1, 1'b0, 1'b1, 0, -1);
        idle(10);
        chk("odd_bad_data", rx_data, 8'h3C);
        chk("odd_bad_perr", parity_err, 1);
        accept();

        // Even parity 0x07 with parity bit 1
        send_frame(8'h07, 2'd2, 1'b1, 1'b1, 0, -1);
        idle(10);
        chk("even_data", rx_data, 8'h07);
        chk("even_perr", parity_err, 0);
        accept();

        // Framing error: stop low plus 3 more low bit times; accepted while line still low
        send_frame(8'h55, 2'd0, 1'b0, 1'b0, 3, 5);
        idle(200);
        chk("frame_data", rx_data, 8'h55);
        chk("frame_err", frame_err, 1);
        chk("frame_no_second", rx_valid, 0);

        // False start: one tick of low
        rx = 1'b0;
        repeat (8) step();
        idle(400);
        chk("false_start_valid", rx_valid, 0);

        // Overrun: back-to-back with no accept
        send_frame(8'h11, 2'd0, 1'b0, 1'b1, 0, -1);
        send_frame(8'h22, 2'd0, 1'b0, 1'b1, 0, -1);
        idle(10);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h22);
        chk("ovr_flag", overrun, 1);
        accept();

        // Accept in the completion cycle of the second word
        send_frame(8'h11, 2'd0, 1'b0, 1'b1, 0, -1);
        send_frame(8'h22, 2'd0, 1'b0, 1'b1, 0, 0);
        idle(10);
        chk("conc_valid", rx_valid, 1);
        chk("conc_data", rx_data, 8'h22);
        chk("conc_ovr", overrun, 0);
        accept();

        // Break: 12 bit times low
        brk_count = 0;
        send_frame(8'h00, 2'd0, 1'b0, 1'b0, 2, 3);
        idle(100);
        chk("brk_data", rx_data, 8'h00);
        chk("brk_ferr", frame_err, 1);
        chk("brk_pulses", brk_count, BRK_EN ? 1 : 0);

        // Reset mid-frame discards the frame
        rx = 1'b0;
        repeat (100) step();
        resetn = 1'b0;
        rx = 1'b1;
        repeat (3) step();
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_data", rx_data, 8'h00);
        resetn = 1'b1;
        idle(400);
        chk("midrst_no_word", rx_valid, 0);

        // Recovery after reset, even parity 0x5A
        send_frame(8'h5A, 2'd2, 1'b0, 1'b1, 0, -1);
        idle(10);
        chk("recover_data", rx_data, 8'h5A);
        chk("recover_flags", {parity_err, frame_err, overrun}, 3'b000);
        accept();
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive side of the UART system.
- Samples the rx line using the shared 4x-oversampling baud tick and recovers 8-bit frames: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Presents each word with a valid/ready handshake to the RX FIFO.
- Flags parity, framing and overrun errors.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronising rx into the clk domain; legal range is 2 or more.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous reset, active-low
- sample_tick  input  1  one-cycle pulse at 4x baud, from the baud rate generator
- PARITY_MODE  input  2  0 = none, 1 = odd, 2 = even, 3 = none
- rx  input  1  serial receive line, asynchronous, idles high
- rx_ready  input  1  consumer accepts rx_data this cycle
- rx_data  output  8  received data word
- rx_valid  output  1  rx_data is valid; held until accepted
- parity_err  output  1  parity mismatch for the word in rx_data
- frame_err  output  1  stop bit sampled low for the word in rx_data
- overrun  output  1  previous unaccepted word was overwritten by this word
- break_det  output  1  break condition pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, resetn low):
  - state = IDLE; tick and bit counters = 0.
  - rx_data = 0; rx_valid, parity_err, frame_err, overrun and break_det = 0.
  - Synchroniser stages preset to 1.
- Synchronisation:
  - All decisions use rx_s, the last synchroniser stage.
  - rx_s lags rx by SYNC_STAGES clk cycles.
- Tick counting:
  - Counters advance only on cycles with sample_tick = 1.
  - One bit time = 4 ticks.
- IDLE:
  - When rx_s = 0: go to START, clear the tick count, and latch PARITY_MODE into a frame-local register.
  - PARITY_MODE changes mid-frame are ignored.
- START:
  - On the tick where tick count = 1, rx_s is checked at mid start bit.
  - If rx_s = 1: false start; return to IDLE with no outputs changed.
  - If rx_s = 0: go to DATA with tick count = 0 and bit count = 0.
  - On other ticks, the tick count increments.
- DATA:
  - On the tick where tick count = 3, shift rx_s into a 9-bit shift register, MSB in, shifting right.
  - N = 9 bits when the latched mode is 1 or 2; otherwise N = 8.
  - After the Nth sample, go to STOP. Otherwise, increment the bit count.
  - The 3-bit tick counter wraps 3 -> 0.
- STOP:
  - On the tick where tick count = 3, sample the stop bit and complete the frame in that cycle.
  - All outputs are registered and update on the following clk edge:
    - rx_data = the 8 data bits.
    - parity_err = received parity != expected parity.
      - Odd mode: expected = ~^data.
      - Even mode: expected = ^data.
      - No-parity modes: parity_err = 0.
    - frame_err = ~stop_sample.
    - overrun = rx_valid & ~rx_ready at the completion cycle.
    - rx_valid = 1.
  - If stop_sample = 1: go to IDLE. Otherwise go to WAIT_IDLE.
- WAIT_IDLE:
  - Remain until rx_s = 1, then go to IDLE.
  - This prevents a low line after a framing error from being taken as a new start bit.
- Only the first stop bit is checked. Extra stop bits from the transmitter appear as idle line.
- Handshake:
  - rx_valid clears on the edge after a cycle with rx_valid & rx_ready.
  - Completion and acceptance in the same cycle: new word loads, rx_valid stays 1, overrun = 0.
  - parity_err, frame_err and overrun travel with the word. They are replaced on each completion and are not cleared on accept.
- Latency: rx_valid rises 1 clk after the clk cycle carrying the stop-sample tick.
- Reset mid-frame: frame discarded immediately; FSM restarts in IDLE.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- When defined: break_det pulses high for exactly 1 clk, aligned with rx_valid rising/reload, when frame_err = 1 and all received data bits are 0 (and the parity bit is 0 if enabled). The word is still delivered normally.
- When undefined: break_det is constant 0 and no break logic is synthesised.

Test Plan:
- Stimulus in every scenario: sample_tick every 8 clk, so 1 bit = 32 clk.
- No parity: drive 0xA5 with 1 stop bit, rx_ready = 0 -> rx_valid = 1, rx_data = 0xA5, all error flags = 0; pulse rx_ready -> rx_valid = 0 the next cycle.
- Odd parity (mode 1): send 0x3C with parity bit 1 -> parity_err = 0. Repeat with parity bit 0 -> parity_err = 1, rx_data = 0x3C.
- Framing error: send 0x55 with stop bit 0, holding rx low 3 more bit times -> frame_err = 1, and no second frame is received until rx returns high.
- False start: drop rx low for 1 tick (8 clk) then high -> FSM returns to IDLE; rx_valid stays 0.
- Overrun and concurrent accept:
  - Receive 0x11 and 0x22 back-to-back with rx_ready = 0 -> rx_data = 0x22, overrun = 1.
  - Repeat with rx_ready pulsed in the completion cycle -> overrun = 0.
- Break (macro defined): hold rx low for 12 bit times -> break_det pulses once for 1 clk, rx_data = 0x00, frame_err = 1.
